// File: rtl/int_divider.sv
// Iterative radix-2 RV32M divider for the DIV execution pipe: one quotient bit per cycle,
// one operation in flight, and the result is held until writeback takes it.
module int_divider #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ix_div_valid_i,
    output logic              ix_div_ready_o,
    input  logic [2*XLEN+6:0] ix_div_i,
    output logic              div_wb_valid_o,
    input  logic              div_wb_ready_i,
    output logic [XLEN+4:0]   div_wb_o
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Issue payload: {rd, rs1, rs2, div_control}; div_control = {is_rem, is_unsigned}.
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic            w_is_unsigned;
    logic            w_is_rem;

    assign w_rd          = ix_div_i[2*XLEN+6 -: 5];
    assign w_rs1         = ix_div_i[2*XLEN+1 -: XLEN];
    assign w_rs2         = ix_div_i[XLEN+1 -: XLEN];
    assign w_is_unsigned = ix_div_i[0];
    assign w_is_rem      = ix_div_i[1];

    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_accept;

    assign w_neg1     = ~w_is_unsigned & w_rs1[XLEN-1];
    assign w_neg2     = ~w_is_unsigned & w_rs2[XLEN-1];
    assign w_abs1     = w_neg1 ? -w_rs1 : w_rs1;
    assign w_abs2     = w_neg2 ? -w_rs2 : w_rs2;
    assign w_div_zero = (w_rs2 == '0);
    assign w_overflow = ~w_is_unsigned & (w_rs1 == INT_MIN) & (&w_rs2);
    assign w_special  = FAST_SPECIAL & (w_div_zero | w_overflow);
    assign w_accept   = ix_div_valid_i & ix_div_ready_o;

    // Overflow DIV returns INT_MIN, which is rs1 itself.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = w_is_rem ? w_rs1 : '1;
        end else begin
            w_special_res = w_is_rem ? '0 : w_rs1;
        end
    end

    logic [4:0]       r_rd;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [XLEN-1:0]  r_dvd;
    logic [XLEN-1:0]  r_dvs;
    logic [XLEN-1:0]  r_rem;
    logic [CNT_W-1:0] r_count;
    logic [XLEN+4:0]  r_wb_data;

    // The shifted partial remainder needs XLEN+1 bits for the compare; the low XLEN bits of
    // the difference are exact because an accepted difference is always below the divisor.
    logic [XLEN:0]   w_rem_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_result;

    assign w_rem_shift = {r_rem, r_dvd[XLEN-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_dvs});
    assign w_diff      = w_rem_shift[XLEN-1:0] - r_dvs;
    assign w_rem_next  = w_ge ? w_diff : w_rem_shift[XLEN-1:0];
    assign w_result    = r_is_rem ? (r_neg_r ? -r_rem : r_rem)
                                  : (r_neg_q ? -r_dvd : r_dvd);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next   = r_state;
        ix_div_ready_o = 1'b0;
        div_wb_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                ix_div_ready_o = ~rst;
                if (w_accept) begin
                    w_state_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == LAST_CNT) begin
                    w_state_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                div_wb_valid_o = 1'b1;
                if (div_wb_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd      <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_count   <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd     <= w_rd;
                        r_is_rem <= w_is_rem;
                        // A zero divisor yields all-ones magnitude that must not be negated.
                        r_neg_q  <= (w_neg1 ^ w_neg2) & ~w_div_zero;
                        r_neg_r  <= w_neg1;
                        r_dvd    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_rem    <= '0;
                        r_count  <= '0;
                        if (w_special) begin
                            r_wb_data <= {w_rd, w_special_res};
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_dvd   <= {r_dvd[XLEN-2:0], w_ge};
                    r_count <= (r_count == LAST_CNT) ? '0 : r_count + 1'b1;
                end
                S_FIXUP: begin
                    r_wb_data <= {r_rd, w_result};
                end
                default: begin
                end
            endcase
        end
    end

    assign div_wb_o = r_wb_data;

    a_hold_under_backpressure: assert property (
        @(posedge clk) disable iff (rst)
        (div_wb_valid_o && !div_wb_ready_i) |=> (div_wb_valid_o && $stable(div_wb_o))
    );

    a_ready_valid_exclusive: assert property (
        @(posedge clk) !(ix_div_ready_o && div_wb_valid_o)
    );

endmodule

// File: tb/tb_int_divider.sv
// Scoreboard bench for int_divider: a fast-special and an iterative-only instance run the
// same hand-computed vectors; a monitor checks results, rd tags, latency and result hold.
module tb_int_divider;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;
    localparam int         NORM_LAT = 34;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  rd;
        bit          special;
    } vec_t;

    typedef struct {
        logic [36:0] data;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [70:0] in_data   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [36:0] out_data  [2];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    vec_t vecs[$];
    exp_t sb_q[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int_divider #(.XLEN(32), .FAST_SPECIAL(1'b1)) u_fast (
        .clk            (clk),
        .rst            (rst),
        .ix_div_valid_i (in_valid[0]),
        .ix_div_ready_o (in_ready[0]),
        .ix_div_i       (in_data[0]),
        .div_wb_valid_o (out_valid[0]),
        .div_wb_ready_i (out_ready[0]),
        .div_wb_o       (out_data[0])
    );

    int_divider #(.XLEN(32), .FAST_SPECIAL(1'b0)) u_slow (
        .clk            (clk),
        .rst            (rst),
        .ix_div_valid_i (in_valid[1]),
        .ix_div_ready_o (in_ready[1]),
        .ix_div_i       (in_data[1]),
        .div_wb_valid_o (out_valid[1]),
        .div_wb_ready_i (out_ready[1]),
        .div_wb_o       (out_data[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] r, input logic [4:0] rd, input bit sp);
        vec_t v;
        v.ctrl = c; v.a = a; v.b = b; v.res = r; v.rd = rd; v.special = sp;
        vecs.push_back(v);
    endfunction

    // Called just after a rising edge; returns just after the accept edge (acc = -1 on timeout).
    task automatic issue(input int d, input logic [1:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                         input int lat, output int acc);
        exp_t e;
        int   waited = 0;
        acc         = -1;
        in_valid[d] = 1'b1;
        in_data[d]  = {rd, a, b, ctrl};
        forever begin
            @(negedge clk);
            if (in_ready[d]) break;
            waited++;
            if (waited > 200) begin
                check($sformatf("accept_timeout[d%0d]", d), 64'(waited), 64'd0);
                in_valid[d] = 1'b0;
                return;
            end
        end
        acc    = cyc;
        e.data = {rd, res};
        e.acc  = cyc;
        e.lat  = lat;
        sb_q[d].push_back(e);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (sb_q[d].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain[d%0d]", d), 64'(sb_q[d].size()), 64'd0);
    endtask

    task automatic run_table(input int d, input bit fast);
        int acc;
        int prev_acc = -1;
        int prev_lat = 0;
        int lat;
        for (int i = 0; i < vecs.size(); i++) begin
            lat = (fast && vecs[i].special) ? 1 : NORM_LAT;
            issue(d, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, lat, acc);
            if (prev_acc >= 0 && acc >= 0) begin
                check($sformatf("accept_spacing[d%0d,v%0d]", d, i),
                      64'(acc - prev_acc), 64'(prev_lat + 1));
            end
            prev_acc = acc;
            prev_lat = lat;
        end
        drain(d);
    endtask

    // Monitor: latency from accept to first valid, result/rd at the WB handshake, hold under stall.
    logic        prev_valid [2];
    logic        prev_ready [2];
    logic [36:0] held       [2];
    int          rise       [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                if (out_valid[d] && !prev_valid[d]) rise[d] = cyc;
                if (out_valid[d]) begin
                    check($sformatf("ready_while_valid[d%0d]", d), 64'(in_ready[d]), 64'd0);
                end
                if (out_valid[d] && prev_valid[d] && !prev_ready[d]) begin
                    check($sformatf("hold_data[d%0d]", d), 64'(out_data[d]), 64'(held[d]));
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (sb_q[d].size() == 0) begin
                        check($sformatf("spurious_out[d%0d]", d), 64'd0, 64'd1);
                    end else begin
                        exp_t e;
                        e = sb_q[d].pop_front();
                        check($sformatf("result[d%0d,rd%0d]", d, e.data[36:32]),
                              64'(out_data[d]), 64'(e.data));
                        check($sformatf("latency[d%0d,rd%0d]", d, e.data[36:32]),
                              64'(rise[d] - e.acc), 64'(e.lat));
                    end
                end
            end
            prev_valid[d] = rst ? 1'b0 : out_valid[d];
            prev_ready[d] = out_ready[d];
            held[d]       = out_data[d];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  n;
        logic saw;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]   = 1'b0;
            in_data[d]    = '0;
            out_ready[d]  = 1'b1;
            prev_valid[d] = 1'b0;
            prev_ready[d] = 1'b1;
            held[d]       = '0;
            rise[d]       = 0;
        end

        add_vec(OP_DIV,  32'd100,       32'd7,         32'h0000_000E, 5'd1,  1'b0);
        add_vec(OP_REM,  32'd100,       32'd7,         32'h0000_0002, 5'd2,  1'b0);
        add_vec(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd3,  1'b0);
        add_vec(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd4,  1'b0);
        add_vec(OP_REMU, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 5'd5,  1'b0);
        add_vec(OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 5'd6,  1'b0);
        add_vec(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd7,  1'b1);
        add_vec(OP_REM,  32'd5,         32'd0,         32'h0000_0005, 5'd8,  1'b1);
        add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd9,  1'b1);
        add_vec(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd10, 1'b1);
        add_vec(OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 5'd11, 1'b1);
        add_vec(OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 5'd12, 1'b1);
        add_vec(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd13, 1'b0);
        add_vec(OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 5'd14, 1'b0);
        add_vec(OP_DIV,  32'h8000_0000, 32'd3,         32'hD555_5556, 5'd15, 1'b0);
        add_vec(OP_REM,  32'h8000_0000, 32'd3,         32'hFFFF_FFFE, 5'd16, 1'b0);
        add_vec(OP_DIVU, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 5'd17, 1'b0);
        add_vec(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'd18, 1'b0);
        add_vec(OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd19, 1'b0);
        add_vec(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd20, 1'b0);
        add_vec(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd21, 1'b0);
        add_vec(OP_DIV,  32'd0,         32'd5,         32'h0000_0000, 5'd0,  1'b0);
        add_vec(OP_DIVU, 32'h1234_5678, 32'd1,         32'h1234_5678, 5'd31, 1'b0);

        // Reset state, then ready in the first cycle after release.
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ready[d%0d]", d), 64'(in_ready[d]), 64'd0);
            check($sformatf("reset_valid[d%0d]", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("reset_data[d%0d]", d), 64'(out_data[d]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ready_after_reset[d%0d]", d), 64'(in_ready[d]), 64'd1);
        end

        @(posedge clk);
        #1;
        run_table(0, 1'b1);
        @(posedge clk);
        #1;
        run_table(1, 1'b0);

        // Backpressure: result held for 10 stalled cycles, next accept one cycle after handshake.
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        issue(0, OP_DIV, 32'd100, 32'd7, 5'd22, 32'h0000_000E, NORM_LAT, acc);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 64'(out_valid[0]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(in_ready[0]), 64'd0);
            check("bp_data_held", 64'(out_data[0]), 64'({5'd22, 32'h0000_000E}));
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_after_handshake", 64'(in_ready[0]), 64'd1);
        check("bp_valid_dropped", 64'(out_valid[0]), 64'd0);
        check("bp_queue_empty", 64'(sb_q[0].size()), 64'd0);

        // Reset at CALC count 16, no stale result, then a fresh DIV 9/3.
        @(posedge clk);
        #1;
        issue(0, OP_DIV, 32'd200, 32'd7, 5'd23, 32'h0000_001C, NORM_LAT, acc);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q[0].delete();
        sb_q[1].delete();
        @(negedge clk);
        check("ready_in_reset", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw = saw | out_valid[0];
        end
        check("no_stale_valid", 64'(saw), 64'd0);
        @(posedge clk);
        #1;
        issue(0, OP_DIV, 32'd9, 32'd3, 5'd24, 32'h0000_0003, NORM_LAT, acc);
        drain(0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
